uart_tx_engine: RTL and testbench
=================================

Name: uart_tx_engine

Overview:
- Transmit framing and shifting stage of the TX_Out path.
- Accepts a parallel byte plus a frame configuration and generates start, data, parity and stop bits at the programmed baud rate.
- Drives tx_bit into the 1-bit output flop that feeds the TX pin.
- Reports readiness to the host and pulses when a frame completes.

Parameters:
- FRAME_LEN, 11: bit-times per frame (fixed frame length, unused slots are stop bits).
- DIV_W, 19: width of the baud divisor input and the baud counter.

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- baud_k  in  DIV_W  clocks per bit-time. 0 is treated as 1.
- eight  in  1  1 = 8 data bits, 0 = 7 data bits.
- pen  in  1  parity enable.
- ohel  in  1  parity sense: 0 = even, 1 = odd.
- load  in  1  single-cycle write strobe for data.
- data  in  8  byte to transmit, LSB first.
- tx_bit  out  1  serial bit, goes to the downstream output register.
- txrdy  out  1  1 = idle, able to accept a load.
- tx_done  out  1  one-cycle pulse at the end of a frame.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, tx_bit=1, txrdy=1, tx_done=0, counters and shift register cleared.
- States: IDLE and SHIFT.
- IDLE -> SHIFT on an edge where load=1 and txrdy=1. On that edge:
  - data, eight, pen and ohel are captured into the 11-bit shift register.
  - txrdy=0 and tx_bit=0 (start bit) from that edge on, so latency from load to the start bit is one edge.
- load while txrdy=0 is ignored, and the frame in flight is unaffected. Config input changes mid-frame are also ignored.
- Frame layout, LSB first, slot 0 = start bit (0):
  - eight=1, pen=1: d0..d7, P, 1
  - eight=1, pen=0: d0..d7, 1, 1
  - eight=0, pen=1: d0..d6, P, 1, 1
  - eight=0, pen=0: d0..d6, 1, 1, 1
- Parity:
  - P = XOR of the active data bits (d7 is excluded when eight=0).
  - P is inverted when ohel=1.
  - With eight=0, data[7] never appears on the line.
- Baud counter:
  - Counts 0 to max(baud_k,1)-1 while in SHIFT, then wraps.
  - The wrap edge shifts the register right (filling with 1) and increments the bit counter.
  - Every slot is held exactly max(baud_k,1) clocks.
- Frame end: the edge where bit counter 10 wraps returns the block to IDLE:
  - tx_bit=1, txrdy=1, tx_done=1 for one cycle.
  - A load sampled on that same edge is ignored, because txrdy was still 0.
  - A load on the next cycle starts a new frame, giving back-to-back frames with no idle gap beyond one clock.
  - Total busy time = 11*max(baud_k,1) clocks.
- baud_k changed mid-frame: takes effect at the next counter wrap comparison. This is not glitch-protected; the host must hold baud_k stable while txrdy=0.
- Reset mid-frame: the frame is aborted immediately. tx_bit returns to 1 asynchronously and txrdy=1.
- tx_bit is registered: no combinational path from any input to tx_bit.

Decomposition:
- Shared package uart_tx_pkg:
  - FRAME_LEN=11.
  - State encoding (IDLE, SHIFT).
  - Parity-select constants for ohel.
- One sub-module: baud_gen. Inputs clk, reset, enable and baud_k; output a one-cycle tick on counter wrap.
- Frame assembly, shift register, bit counter and FSM stay in uart_tx_engine.

Test Plan:
- Reset then idle: reset pulsed low with no loads -> tx_bit=1, txrdy=1, tx_done=0 held for 100 clocks.
- Parity, 8-bit even: baud_k=4, eight=1, pen=1, ohel=0, load data=8'hA5 -> line 0,1,0,1,0,0,1,0,1,0,1, each bit held 4 clocks. txrdy low for exactly 44 clocks, tx_done pulses once.
- Parity, 7-bit odd: baud_k=4, eight=0, pen=1, ohel=1, data=8'hC1 -> line 0,1,0,0,0,0,0,1,1,1,1 (P=1, d7 dropped).
- Ignored load and fast divisor: baud_k=0, eight=1, pen=0, load 8'h3C, then load 8'hFF at cycle 5 -> line 0,0,0,1,1,1,1,0,0,1,1 at one clock per bit. Second load ignored, txrdy rises after 11 clocks.
- Reset mid-frame: baud_k=8, load 8'h00, assert reset at clock 30 -> tx_bit=1 and txrdy=1 immediately. After release, a new load of 8'h55 produces a correct full frame.
- Back-to-back: load 8'h81 and then 8'h7E on the first cycle txrdy=1 (baud_k=2) -> two complete frames separated by exactly one idle clock at 1, with two tx_done pulses.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit engine: frame geometry,
// FSM state encoding, parity sense constants and frame assembly helpers.
package uart_tx_pkg;

  localparam int FRAME_LEN = 11;

  localparam logic [3:0] LAST_SLOT = 4'(FRAME_LEN - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Parity over the active data bits; d7 only counts in 8-bit mode.
  function automatic logic calc_parity(input logic [7:0] d,
                                       input logic       eight,
                                       input logic       ohel);
    logic p;
    p = ^d[6:0];
    if (eight) begin
      p = p ^ d[7];
    end else begin
      p = p;
    end
    return (ohel == PAR_ODD) ? ~p : p;
  endfunction

  // Full line image, slot 0 (start bit) in bit 0; unused slots are stop bits.
  function automatic logic [FRAME_LEN-1:0] build_frame(input logic [7:0] d,
                                                       input logic       eight,
                                                       input logic       pen,
                                                       input logic       ohel);
    logic                 par;
    logic [FRAME_LEN-1:0] f;
    par    = pen ? calc_parity(d, eight, ohel) : 1'b1;
    f      = {FRAME_LEN{1'b1}};
    f[0]   = 1'b0;
    f[7:1] = d[6:0];
    if (eight) begin
      f[8] = d[7];
      f[9] = par;
    end else begin
      f[8] = par;
    end
    return f;
  endfunction

endpackage

// File: rtl/uart_tx_engine_baud_gen.sv
// Bit-time divider: counts while enabled and emits a one-cycle tick on wrap.
// A divisor of 0 behaves as 1 (tick every enabled clock).
module baud_gen
  #(parameter int DIV_W = 19)
  (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [DIV_W-1:0] baud_k,
    output logic             tick
  );

  localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};

  logic [DIV_W-1:0] cnt_r;
  logic [DIV_W-1:0] limit_s;

  // Effective divisor and wrap detect; >= recovers if baud_k shrinks mid-count.
  always_comb begin
    limit_s = (baud_k == DIV_ZERO) ? DIV_ONE : baud_k;
    tick    = enable && (cnt_r >= (limit_s - DIV_ONE));
  end

  // Bit-time counter, held at zero while the engine is idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= DIV_ZERO;
    end else if (!enable || tick) begin
      cnt_r <= DIV_ZERO;
    end else begin
      cnt_r <= cnt_r + DIV_ONE;
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit framing/shifting stage: captures a byte plus frame config,
// then shifts start, data, parity and stop bits out at the programmed rate.
module uart_tx_engine
  import uart_tx_pkg::*;
  #(parameter int DIV_W = 19)
  (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] baud_k,
    input  logic             eight,
    input  logic             pen,
    input  logic             ohel,
    input  logic             load,
    input  logic [7:0]       data,
    output logic             tx_bit,
    output logic             txrdy,
    output logic             tx_done
  );

  tx_state_e            state_r, state_s;
  logic [FRAME_LEN-1:0] shreg_r, shreg_s;
  logic [FRAME_LEN-1:0] frame_s;
  logic [3:0]           bitcnt_r, bitcnt_s;
  logic                 tx_bit_r, tx_bit_s;
  logic                 txrdy_r, txrdy_s;
  logic                 tx_done_r, tx_done_s;
  logic                 tick_s;
  logic                 shift_en_s;

  assign shift_en_s = (state_r == ST_SHIFT);

  baud_gen #(.DIV_W(DIV_W)) u_baud_gen (
    .clk    (clk),
    .reset  (reset),
    .enable (shift_en_s),
    .baud_k (baud_k),
    .tick   (tick_s)
  );

  // Next-state and next-output logic; defaults hold state, tx_done pulses.
  always_comb begin
    frame_s   = build_frame(data, eight, pen, ohel);
    state_s   = state_r;
    shreg_s   = shreg_r;
    bitcnt_s  = bitcnt_r;
    tx_bit_s  = tx_bit_r;
    txrdy_s   = txrdy_r;
    tx_done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (load && txrdy_r) begin
          state_s  = ST_SHIFT;
          tx_bit_s = frame_s[0];
          shreg_s  = {1'b1, frame_s[FRAME_LEN-1:1]};
          bitcnt_s = 4'd0;
          txrdy_s  = 1'b0;
        end else begin
          tx_bit_s = 1'b1;
          txrdy_s  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (tick_s && (bitcnt_r == LAST_SLOT)) begin
          state_s   = ST_IDLE;
          tx_bit_s  = 1'b1;
          txrdy_s   = 1'b1;
          tx_done_s = 1'b1;
          bitcnt_s  = 4'd0;
        end else if (tick_s) begin
          tx_bit_s = shreg_r[0];
          shreg_s  = {1'b1, shreg_r[FRAME_LEN-1:1]};
          bitcnt_s = bitcnt_r + 4'd1;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      default: begin
        state_s  = ST_IDLE;
        tx_bit_s = 1'b1;
        txrdy_s  = 1'b1;
        bitcnt_s = 4'd0;
      end
    endcase
  end

  // State, shift register, bit counter and output flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      shreg_r   <= {FRAME_LEN{1'b0}};
      bitcnt_r  <= 4'd0;
      tx_bit_r  <= 1'b1;
      txrdy_r   <= 1'b1;
      tx_done_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      shreg_r   <= shreg_s;
      bitcnt_r  <= bitcnt_s;
      tx_bit_r  <= tx_bit_s;
      txrdy_r   <= txrdy_s;
      tx_done_r <= tx_done_s;
    end
  end

  assign tx_bit  = tx_bit_r;
  assign txrdy   = txrdy_r;
  assign tx_done = tx_done_r;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: stimulus pushes expected line images,
// a negedge monitor pops and compares every clock of every frame.
module tb_uart_tx_engine;

  localparam int DIV_W = 19;

  logic             clk    = 1'b0;
  logic             reset  = 1'b0;
  logic [DIV_W-1:0] baud_k = '0;
  logic             eight  = 1'b1;
  logic             pen    = 1'b0;
  logic             ohel   = 1'b0;
  logic             load   = 1'b0;
  logic [7:0]       data   = 8'h00;
  logic             tx_bit;
  logic             txrdy;
  logic             tx_done;

  typedef struct packed {
    logic [10:0] bits;
    logic [19:0] k;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   active = 1'b0;
  bit   pend   = 1'b0;

  uart_tx_engine #(.DIV_W(DIV_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .baud_k  (baud_k),
    .eight   (eight),
    .pen     (pen),
    .ohel    (ohel),
    .load    (load),
    .data    (data),
    .tx_bit  (tx_bit),
    .txrdy   (txrdy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;

  // Line image built from the framing rules: start, n data bits, optional
  // parity, then stop bits padding out to 11 slots.
  function automatic logic [10:0] model_frame(input logic [7:0] d, input logic e,
                                              input logic p, input logic o);
    logic [10:0] f;
    int          n;
    int          idx;
    int          ones;
    n    = e ? 8 : 7;
    f    = '1;
    f[0] = 1'b0;
    idx  = 1;
    ones = 0;
    for (int i = 0; i < n; i++) begin
      f[idx] = d[i];
      ones   = ones + int'(d[i]);
      idx++;
    end
    if (p) begin
      f[idx] = ((ones % 2) == 1) ^ o;
    end
    return f;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares idle, busy, end-of-frame and reset behaviour each clock.
  initial begin
    exp_t        cur;
    int unsigned nclk;
    int unsigned slot;
    cur  = '0;
    nclk = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        active = 1'b0;
        pend   = 1'b0;
        chk("reset_tx_bit", tx_bit, 1);
        chk("reset_txrdy", txrdy, 1);
        chk("reset_tx_done", tx_done, 0);
      end else if (pend) begin
        pend = 1'b0;
        chk("end_tx_done", tx_done, 1);
        chk("end_txrdy", txrdy, 1);
        chk("end_tx_bit", tx_bit, 1);
      end else if (!active) begin
        if (txrdy == 1'b0) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: got txrdy 0, expected idle at %0t", $time);
          end else begin
            cur    = exp_q.pop_front();
            active = 1'b1;
            nclk   = 0;
          end
        end else begin
          chk("idle_tx_bit", tx_bit, 1);
          chk("idle_tx_done", tx_done, 0);
        end
      end
      if (active) begin
        slot = nclk / cur.k;
        chk($sformatf("slot%0d_bit", slot), tx_bit, cur.bits[slot]);
        chk("busy_txrdy", txrdy, 0);
        chk("busy_tx_done", tx_done, 0);
        nclk++;
        if (nclk == 11 * cur.k) begin
          active = 1'b0;
          pend   = 1'b1;
        end
      end
    end
  end

  // Issue one accepted load at the first idle clock; queue its expected frame.
  task automatic send(input logic [7:0] d, input logic e, input logic p,
                      input logic o, input logic [DIV_W-1:0] k);
    int   w;
    exp_t ex;
    w = 0;
    @(negedge clk);
    while (!txrdy && w < 5000) begin
      @(negedge clk);
      w++;
    end
    if (!txrdy) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got txrdy 0, expected 1 at %0t", $time);
    end else begin
      baud_k  = k;
      data    = d;
      eight   = e;
      pen     = p;
      ohel    = o;
      load    = 1'b1;
      ex.bits = model_frame(d, e, p, o);
      ex.k    = (k == '0) ? 20'd1 : 20'(k);
      exp_q.push_back(ex);
      @(posedge clk);
      #1;
      load  = 1'b0;
      data  = 8'($urandom);
      eight = 1'($urandom);
      pen   = 1'($urandom);
      ohel  = 1'($urandom);
    end
  endtask

  // Pulse load while a frame is in flight; it must have no effect.
  task automatic busy_load(input logic [7:0] d);
    @(negedge clk);
    data = d;
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || active || pend) && w < 5000) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    chk("drain_queue", exp_q.size(), 0);
  endtask

  // Directed scenarios followed by randomized frames.
  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (100) @(negedge clk);

    send(8'hA5, 1'b1, 1'b1, 1'b0, 19'd4);
    wait_idle();
    send(8'hC1, 1'b0, 1'b1, 1'b1, 19'd4);
    wait_idle();

    send(8'h3C, 1'b1, 1'b0, 1'b0, 19'd0);
    repeat (3) @(negedge clk);
    busy_load(8'hFF);
    wait_idle();

    send(8'h00, 1'b1, 1'b1, 1'b0, 19'd8);
    repeat (30) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_tx_bit", tx_bit, 1);
    chk("abort_txrdy", txrdy, 1);
    chk("abort_tx_done", tx_done, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    send(8'h55, 1'b1, 1'b1, 1'b0, 19'd8);
    wait_idle();

    send(8'h81, 1'b1, 1'b1, 1'b0, 19'd2);
    send(8'h7E, 1'b1, 1'b1, 1'b0, 19'd2);
    wait_idle();

    for (int i = 0; i < 25; i++) begin
      send(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           19'($urandom_range(0, 5)));
      if ($urandom_range(0, 3) == 0) begin
        busy_load(8'($urandom));
      end
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 4)) @(negedge clk);
      end
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
